// File: rtl/uart_16550_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_16550_tx_if
// Description : Register-side bus between the 16550 register block and the
//               transmit stage: THR writes, LCR/FCR controls and TX status.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_16550_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  logic                          wr_en;
  logic [7:0]                    wr_data;
  logic [7:0]                    lcr;
  logic                          fifo_en;
  logic                          tx_fifo_clr;
  logic                          tx_ready;
  logic                          tx_empty;
  logic                          tx_overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  // Register block side: drives THR writes and line/FIFO control.
  modport master (
    output wr_en, wr_data, lcr, fifo_en, tx_fifo_clr,
    input  tx_ready, tx_empty, tx_overflow, fifo_count
  );

  // Transmitter side: consumes controls and reports status.
  modport slave (
    input  wr_en, wr_data, lcr, fifo_en, tx_fifo_clr,
    output tx_ready, tx_empty, tx_overflow, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/uart_16550_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_16550_tx
// Description : 16550 transmit stage. TX FIFO (or single holding register
//               when FIFOs are disabled) feeding a frame serialiser clocked
//               by the 16x baud tick. Optional macro UART_TX_BREAK_EN lets
//               LCR[6] force the line low after the output register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_16550_tx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            baud_tick_i,
  uart_16550_tx_if.slave  bus_if,
  output logic            tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_en_q;
  logic          ovf_q;

  // ----------------------------------------------------------- serialiser
  state_t        state_q;
  logic [4:0]    tick_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic [5:0]    lcr_q;
  logic          par_q;
  logic          tx_q;

  logic          w_flush;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_ok;
  logic          w_drop;
  logic          w_frame_end;
  logic [7:0]    w_head;
  logic [7:0]    w_mask;
  logic          w_par;
  logic [4:0]    w_stop_last;
  logic [2:0]    w_last_bit;

  // Toggling the FIFO enable empties the buffer just like an explicit clear.
  assign w_flush = bus_if.tx_fifo_clr | (bus_if.fifo_en != fifo_en_q);

  // Capacity is the full depth with FIFOs on, one entry in holding-register mode.
  assign w_full = bus_if.fifo_en ? (count_q == C_DEPTH) : (count_q != '0);

  // Frame-relative constants derived from the LCR latched at frame start.
  assign w_last_bit  = {1'b1, lcr_q[1:0]};
  assign w_stop_last = !lcr_q[2]           ? 5'd15 :
                       (lcr_q[1:0] == 2'b00) ? 5'd23 : 5'd31;
  assign w_frame_end = (state_q == S_STOP) && (tick_cnt_q == w_stop_last);

  // A pop happens on the tick that starts a frame: from IDLE, or chained off the last STOP tick.
  assign w_pop = baud_tick_i && (count_q != '0) &&
                 ((state_q == S_IDLE) || w_frame_end);

  // A write at capacity still lands if the same cycle frees a slot.
  assign w_wr_ok = bus_if.wr_en && !w_flush && (!w_full || w_pop);
  assign w_drop  = bus_if.wr_en && !w_flush && w_full && !w_pop;

  // Parity is computed from the head byte masked to the live word length,
  // which is the same LCR value latched for the frame.
  assign w_head = mem_q[rd_ptr_q];
  assign w_mask = 8'hFF >> (2'd3 - bus_if.lcr[1:0]);
  assign w_par  = bus_if.lcr[5] ? ~bus_if.lcr[4] :
                  bus_if.lcr[4] ? ^(w_head & w_mask) : ~^(w_head & w_mask);

  // Next-state for FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (w_pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({w_wr_ok, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO bookkeeping registers and the overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      fifo_en_q <= bus_if.fifo_en;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= w_drop;
      fifo_en_q <= bus_if.fifo_en;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr_ok) mem_q[wr_ptr_q] <= bus_if.wr_data;
  end

  // Frame serialiser: all state advances only on baud ticks, tx is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= 5'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      lcr_q      <= 6'h00;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else if (baud_tick_i) begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (w_pop) begin
            state_q    <= S_START;
            tick_cnt_q <= 5'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= w_head;
            lcr_q      <= bus_if.lcr[5:0];
            par_q      <= w_par;
            tx_q       <= 1'b0;
          end
        end
        S_START: begin
          if (tick_cnt_q == 5'd15) begin
            state_q    <= S_DATA;
            tick_cnt_q <= 5'd0;
            bit_idx_q  <= 3'd0;
            tx_q       <= shift_q[0];
          end else begin
            tick_cnt_q <= tick_cnt_q + 5'd1;
          end
        end
        S_DATA: begin
          if (tick_cnt_q == 5'd15) begin
            tick_cnt_q <= 5'd0;
            if (bit_idx_q == w_last_bit) begin
              if (lcr_q[3]) begin
                state_q <= S_PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + 5'd1;
          end
        end
        S_PARITY: begin
          if (tick_cnt_q == 5'd15) begin
            state_q    <= S_STOP;
            tick_cnt_q <= 5'd0;
            tx_q       <= 1'b1;
          end else begin
            tick_cnt_q <= tick_cnt_q + 5'd1;
          end
        end
        S_STOP: begin
          if (w_frame_end) begin
            tick_cnt_q <= 5'd0;
            bit_idx_q  <= 3'd0;
            if (w_pop) begin
              // Chain straight into the next start bit, no idle gap.
              state_q <= S_START;
              shift_q <= w_head;
              lcr_q   <= bus_if.lcr[5:0];
              par_q   <= w_par;
              tx_q    <= 1'b0;
            end else begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            tick_cnt_q <= tick_cnt_q + 5'd1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          tick_cnt_q <= 5'd0;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  assign bus_if.tx_ready    = (count_q == '0);
  assign bus_if.tx_empty    = (count_q == '0) && (state_q == S_IDLE);
  assign bus_if.tx_overflow = ovf_q;
  assign bus_if.fifo_count  = count_q;

`ifdef UART_TX_BREAK_EN
  // Break overrides the line after the output register; framing keeps running.
  assign tx_o = tx_q & ~bus_if.lcr[6];
`else
  assign tx_o = tx_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_16550_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_16550_tx
// Description : Self-checking bench for uart_16550_tx. Expected line levels
//               are generated per baud tick from the frame format rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_16550_tx;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic baud_tick = 1'b0;
  logic tx;

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_seen = 0;
  bit exp_q[$];

  uart_16550_tx_if #(.FIFO_DEPTH(DEPTH)) bus_if ();

  uart_16550_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick_i (baud_tick),
    .bus_if      (bus_if),
    .tx_o        (tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus_if.tx_overflow === 1'b1) ovf_seen++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Append the expected per-tick line levels of one frame.
  task automatic push_frame(input logic [7:0] d, input logic [7:0] l);
    int w, ones, stop;
    bit p;
    w = 5 + int'(l[1:0]);
    ones = 0;
    for (int i = 0; i < w; i++) ones += int'(d[i]);
    if (l[5])      p = ~l[4];
    else if (l[4]) p = (ones % 2) == 1;
    else           p = (ones % 2) == 0;
    stop = !l[2] ? 16 : (w == 5 ? 24 : 32);
    repeat (16) exp_q.push_back(1'b0);
    for (int i = 0; i < w; i++) repeat (16) exp_q.push_back(d[i]);
    if (l[3]) repeat (16) exp_q.push_back(p);
    repeat (stop) exp_q.push_back(1'b1);
  endtask

  task automatic tick();
    @(negedge clk) baud_tick = 1'b1;
    @(negedge clk) baud_tick = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    bus_if.wr_en = 1'b1;
    bus_if.wr_data = d;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
  endtask

  // Issue n ticks, comparing tx with the model after each one.
  task automatic run_ticks(input int n, input string name);
    int bad_at;
    logic got;
    bit want, want_bad;
    bad_at = -1;
    got = 1'b0;
    want_bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
      if (tx !== want && bad_at < 0) begin
        bad_at = i;
        got = tx;
        want_bad = want;
      end
    end
    n_checks++;
    if (bad_at >= 0) begin
      n_fail++;
      $display("FAIL %s: tick %0d tx=%b expected %b", name, bad_at, got, want_bad);
    end
  endtask

  // One more tick past the last stop tick: line idle and transmitter empty.
  task automatic end_check(input string name);
    tick();
    n_checks++;
    if (tx !== 1'b1 || bus_if.tx_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_end: tx=%b tx_empty=%b expected 1 1", name, tx, bus_if.tx_empty);
    end
  endtask

  task automatic test_reset();
    bus_if.wr_en = 1'b0;
    bus_if.wr_data = 8'h00;
    bus_if.lcr = 8'h03;
    bus_if.fifo_en = 1'b1;
    bus_if.tx_fifo_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1 || bus_if.tx_ready !== 1'b1 || bus_if.tx_empty !== 1'b1 ||
        bus_if.tx_overflow !== 1'b0 || bus_if.fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL reset: tx=%b ready=%b empty=%b ovf=%b count=%0d expected 1 1 1 0 0",
               tx, bus_if.tx_ready, bus_if.tx_empty, bus_if.tx_overflow, bus_if.fifo_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_8n1();
    bus_if.lcr = 8'h03;
    wr(8'h55);
    n_checks++;
    if (bus_if.fifo_count !== 5'd1 || bus_if.tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1_write: count=%0d ready=%b expected 1 0", bus_if.fifo_count, bus_if.tx_ready);
    end
    push_frame(8'h55, 8'h03);
    run_ticks(1, "8n1_start");
    n_checks++;
    if (bus_if.tx_ready !== 1'b1 || bus_if.tx_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1_pop: ready=%b empty=%b expected 1 0", bus_if.tx_ready, bus_if.tx_empty);
    end
    run_ticks(159, "8n1_frame");
    n_checks++;
    if (bus_if.tx_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL 8n1_last_stop: tx_empty=%b expected 0", bus_if.tx_empty);
    end
    end_check("8n1");
  endtask

  task automatic test_parity();
    bus_if.lcr = 8'h1B;
    wr(8'h07);
    push_frame(8'h07, 8'h1B);
    run_ticks(176, "8e1_frame");
    end_check("8e1");
  endtask

  task automatic test_5bit_stop15();
    bus_if.lcr = 8'h04;
    wr(8'h1F);
    push_frame(8'h1F, 8'h04);
    run_ticks(16 + 80 + 24, "5n15_frame");
    end_check("5n15");
  endtask

  task automatic test_fifo_overflow();
    bus_if.lcr = 8'h03;
    ovf_seen = 0;
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      bus_if.wr_en = 1'b1;
      bus_if.wr_data = 8'(i);
      @(negedge clk);
    end
    bus_if.wr_en = 1'b0;
    n_checks++;
    if (bus_if.tx_overflow !== 1'b1 || bus_if.fifo_count !== 5'd16) begin
      n_fail++;
      $display("FAIL fifo_full: ovf=%b count=%0d expected 1 16", bus_if.tx_overflow, bus_if.fifo_count);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ovf_seen != 1 || bus_if.tx_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_ovf_pulses: pulses=%0d ovf=%b expected 1 0", ovf_seen, bus_if.tx_overflow);
    end
    for (int i = 0; i < 16; i++) push_frame(8'(i), 8'h03);
    run_ticks(16 * 160, "fifo_b2b");
    end_check("fifo_b2b");
  endtask

  task automatic test_holding_mode();
    bus_if.fifo_en = 1'b0;
    bus_if.lcr = 8'h03;
    repeat (2) @(negedge clk);
    ovf_seen = 0;
    bus_if.wr_en = 1'b1;
    bus_if.wr_data = 8'hAA;
    @(negedge clk);
    bus_if.wr_data = 8'hBB;
    @(negedge clk);
    bus_if.wr_en = 1'b0;
    n_checks++;
    if (bus_if.tx_overflow !== 1'b1 || bus_if.fifo_count !== 5'd1) begin
      n_fail++;
      $display("FAIL hold_drop: ovf=%b count=%0d expected 1 1", bus_if.tx_overflow, bus_if.fifo_count);
    end
    push_frame(8'hAA, 8'h03);
    run_ticks(40, "hold_frame_a");
    wr(8'hCC);
    n_checks++;
    if (bus_if.fifo_count !== 5'd1) begin
      n_fail++;
      $display("FAIL hold_refill: count=%0d expected 1", bus_if.fifo_count);
    end
    @(negedge clk) bus_if.tx_fifo_clr = 1'b1;
    @(negedge clk) bus_if.tx_fifo_clr = 1'b0;
    n_checks++;
    if (bus_if.fifo_count !== 5'd0 || bus_if.tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_clear: count=%0d ready=%b expected 0 1", bus_if.fifo_count, bus_if.tx_ready);
    end
    run_ticks(120, "hold_frame_b");
    end_check("hold");
    repeat (32) exp_q.push_back(1'b1);
    run_ticks(32, "hold_idle");
    bus_if.fifo_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    bus_if.lcr = 8'h03;
    wr(8'h3C);
    wr(8'hC3);
    push_frame(8'h3C, 8'h03);
    run_ticks(60, "rst_pre");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
    n_checks++;
    if (tx !== 1'b1 || bus_if.fifo_count !== 5'd0 || bus_if.tx_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: tx=%b count=%0d empty=%b expected 1 0 1", tx, bus_if.fifo_count, bus_if.tx_empty);
    end
`ifdef UART_TX_BREAK_EN
    bus_if.lcr = 8'h43;
    #1;
    n_checks++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL break: tx=%b expected 0", tx);
    end
    bus_if.lcr = 8'h03;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (tx !== 1'b1 || bus_if.fifo_count !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_after: tx=%b count=%0d expected 1 0", tx, bus_if.fifo_count);
    end
  endtask

  // Random formats and bytes; LCR changes after the first pop only affect later frames.
  task automatic test_random();
    logic [7:0] l1, l2, d;
    int nb;
    for (int it = 0; it < 6; it++) begin
      l1 = 8'($urandom) & 8'h3F;
      l2 = 8'($urandom) & 8'h3F;
      nb = $urandom_range(1, 3);
      bus_if.lcr = l1;
      for (int k = 0; k < nb; k++) begin
        d = 8'($urandom);
        wr(d);
        push_frame(d, (k == 0) ? l1 : l2);
      end
      run_ticks(1, "rand_start");
      bus_if.lcr = l2;
      d = 8'($urandom);
      wr(d);
      push_frame(d, l2);
      run_ticks(exp_q.size(), "rand_frames");
      end_check("rand");
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_5bit_stop15();
    test_fifo_overflow();
    test_holding_mode();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
